// File: rtl/mii_pkg.sv
// rtl/mii_pkg.sv - shared codes, state type and beat decoders for the MII frame scheduler
package mii_pkg;

    localparam logic [7:0] IDLE_CODE  = 8'h07;
    localparam logic [7:0] START_CODE = 8'hFB;
    localparam logic [7:0] EOF_CODE   = 8'hFD;
    localparam logic [7:0] NO_PADDING = 8'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_ACTIVE
    } sched_state_e;

    function automatic logic is_start_beat(input logic [63:0] d, input logic [7:0] c);
        return c[0] && (d[7:0] == START_CODE);
    endfunction

    // Any terminate lane marks the beat; later lanes carry nothing of interest.
    function automatic logic is_eof_beat(input logic [63:0] d, input logic [7:0] c);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (c[i] && (d[8*i +: 8] == EOF_CODE)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/mii_frame_scheduler_if.sv
// rtl/mii_frame_scheduler_if.sv - request, generator-monitor and generator-control bundle
interface mii_frame_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int SEL_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    i_req;
    logic [N_REQ*16-1:0] i_payload_length;
    logic [N_REQ*8-1:0]  i_mode;
    logic [63:0]         i_mii_tx_d;
    logic [7:0]          i_mii_tx_c;
    logic [N_REQ-1:0]    o_ack;
    logic                o_err;
    logic                o_gen_rst_n;
    logic [SEL_W-1:0]    o_sel;
    logic [15:0]         o_payload_length;
    logic [7:0]          o_mode;
    logic                o_busy;
    logic [31:0]         o_frame_cnt;

    modport master (
        output i_req, i_payload_length, i_mode, i_mii_tx_d, i_mii_tx_c,
        input  o_ack, o_err, o_gen_rst_n, o_sel, o_payload_length, o_mode, o_busy, o_frame_cnt
    );

    modport slave (
        input  i_req, i_payload_length, i_mode, i_mii_tx_d, i_mii_tx_c,
        output o_ack, o_err, o_gen_rst_n, o_sel, o_payload_length, o_mode, o_busy, o_frame_cnt
    );
endinterface

// File: rtl/mii_frame_scheduler_rr_arbiter.sv
// rtl/mii_frame_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int SEL_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);
    int j;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!gnt_valid && req[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(j);
            end
        end
    end
endmodule

// File: rtl/mii_frame_scheduler.sv
// rtl/mii_frame_scheduler.sv - shares one MII frame generator among N_REQ sources with watchdog
module mii_frame_scheduler
    import mii_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int SEL_W   = $clog2(N_REQ),
    parameter int TIMEOUT = 512
) (
    input  logic                  clk,
    input  logic                  i_rst,
    mii_frame_scheduler_if.slave  bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    sched_state_e     state_q, state_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [15:0]      len_q, len_d;
    logic [7:0]       mode_q, mode_d;
    logic             gen_rst_n_q, gen_rst_n_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [31:0]      frame_cnt_q, frame_cnt_d;

    logic [N_REQ-1:0] arb_req;
    logic [SEL_W-1:0] arb_ptr, sel_inc, gnt_idx;
    logic             gnt_valid, eof_hit, timeout_hit;

    // While a frame is running the arbiter looks ahead for the successor, skipping the current source.
    always_comb begin
        sel_inc     = (int'(sel_q) == N_REQ - 1) ? '0 : sel_q + 1'b1;
        arb_ptr     = (state_q == ST_IDLE) ? rr_ptr_q : sel_inc;
        arb_req     = bus.i_req;
        if (state_q != ST_IDLE) begin
            arb_req[sel_q] = 1'b0;
        end
        eof_hit     = (state_q == ST_ACTIVE) && is_eof_beat(bus.i_mii_tx_d, bus.i_mii_tx_c);
        timeout_hit = (state_q != ST_IDLE) && (wd_q == WD_W'(TIMEOUT - 1));
    end

    rr_arbiter #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_arb (
        .req       (arb_req),
        .ptr       (arb_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        wd_d        = wd_q;
        sel_d       = sel_q;
        len_d       = len_q;
        mode_d      = mode_q;
        gen_rst_n_d = gen_rst_n_q;
        ack_d       = '0;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            ST_IDLE: begin
                gen_rst_n_d = 1'b0;
                wd_d        = '0;
                if (gnt_valid) begin
                    sel_d       = gnt_idx;
                    len_d       = bus.i_payload_length[int'(gnt_idx)*16 +: 16];
                    mode_d      = bus.i_mode[int'(gnt_idx)*8 +: 8];
                    gen_rst_n_d = 1'b1;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH, ST_ACTIVE: begin
                wd_d = wd_q + 1'b1;
                // EOF is checked before the watchdog so a frame ending on the last cycle still counts.
                if (eof_hit) begin
                    ack_d[sel_q] = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 32'd1;
                    rr_ptr_d     = sel_inc;
                    if (gnt_valid) begin
                        sel_d       = gnt_idx;
                        len_d       = bus.i_payload_length[int'(gnt_idx)*16 +: 16];
                        mode_d      = bus.i_mode[int'(gnt_idx)*8 +: 8];
                        gen_rst_n_d = 1'b1;
                        wd_d        = '0;
                        state_d     = ST_LAUNCH;
                    end else begin
                        gen_rst_n_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end else if (timeout_hit) begin
                    err_d        = 1'b1;
                    ack_d[sel_q] = 1'b1;
                    rr_ptr_d     = sel_inc;
                    gen_rst_n_d  = 1'b0;
                    state_d      = ST_IDLE;
                end else if (state_q == ST_LAUNCH && is_start_beat(bus.i_mii_tx_d, bus.i_mii_tx_c)) begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                gen_rst_n_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            wd_q        <= '0;
            sel_q       <= '0;
            len_q       <= '0;
            mode_q      <= '0;
            gen_rst_n_q <= 1'b0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            wd_q        <= wd_d;
            sel_q       <= sel_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            gen_rst_n_q <= gen_rst_n_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.o_ack            = ack_q;
    assign bus.o_err            = err_q;
    assign bus.o_gen_rst_n      = gen_rst_n_q;
    assign bus.o_sel            = sel_q;
    assign bus.o_payload_length = len_q;
    assign bus.o_mode           = mode_q;
    assign bus.o_busy           = busy_q;
    assign bus.o_frame_cnt      = frame_cnt_q;
endmodule

// File: tb/tb_mii_frame_scheduler.sv
// tb/tb_mii_frame_scheduler.sv - scoreboard bench with a behavioural 64-bit MII generator
module tb_mii_frame_scheduler;
    import mii_pkg::*;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 512;

    typedef struct {
        int   src;
        logic err;
    } exp_t;

    logic clk = 1'b0;
    logic i_rst;
    bit   hold_req;
    bit   gen_en;
    int   checks = 0;
    int   errors = 0;
    int   ack_cnt = 0;
    exp_t exp_q[$];

    mii_frame_scheduler_if #(.N_REQ(N_REQ)) bus ();

    mii_frame_scheduler #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int frame_bytes(input logic [15:0] len, input logic [7:0] mode);
        int pay;
        pay = int'(len);
        if (mode != NO_PADDING && pay < 46) pay = 46;
        return 26 + pay;
    endfunction

    // Generator: two idle beats after release or after EOF, START, data, then EOF in lane bytes%8.
    initial begin
        int k;
        int nb;
        k = 0;
        nb = 0;
        bus.i_mii_tx_d = {8{IDLE_CODE}};
        bus.i_mii_tx_c = 8'hFF;
        forever begin
            @(negedge clk);
            bus.i_mii_tx_d = {8{IDLE_CODE}};
            bus.i_mii_tx_c = 8'hFF;
            if (bus.o_gen_rst_n !== 1'b1 || !gen_en) begin
                k = 0;
            end else begin
                if (k == 2) begin
                    nb = frame_bytes(bus.o_payload_length, bus.o_mode);
                    bus.i_mii_tx_d = {{7{8'h55}}, START_CODE};
                    bus.i_mii_tx_c = 8'h01;
                end else if (k > 2 && k < 2 + nb / 8) begin
                    bus.i_mii_tx_d = {8{8'hA5}};
                    bus.i_mii_tx_c = 8'h00;
                end else if (k > 2 && k == 2 + nb / 8) begin
                    for (int l = 0; l < 8; l++) begin
                        if (l < nb % 8) begin
                            bus.i_mii_tx_d[8*l +: 8] = 8'h3C;
                            bus.i_mii_tx_c[l]        = 1'b0;
                        end else if (l == nb % 8) begin
                            bus.i_mii_tx_d[8*l +: 8] = EOF_CODE;
                        end
                    end
                end
                k = (k > 2 && k == 2 + nb / 8) ? 0 : k + 1;
            end
        end
    end

    task automatic step();
        exp_t e;
        logic [N_REQ-1:0] exp_ack;
        @(posedge clk);
        #1;
        if (bus.o_ack !== '0 || bus.o_err !== 1'b0) begin
            checks++;
            ack_cnt++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got ack=%b err=%b expected no ack", bus.o_ack, bus.o_err);
            end else begin
                e = exp_q.pop_front();
                exp_ack = '0;
                exp_ack[e.src] = 1'b1;
                if (bus.o_ack !== exp_ack || bus.o_err !== e.err) begin
                    errors++;
                    $display("FAIL scoreboard_ack: got ack=%b err=%b expected ack=%b err=%b",
                             bus.o_ack, bus.o_err, exp_ack, e.err);
                end
            end
            if (!hold_req) bus.i_req = bus.i_req & ~bus.o_ack;
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
    endtask

    task automatic wait_release(output int n);
        n = 0;
        while (bus.o_gen_rst_n !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic wait_ack(output int lat);
        int target;
        target = ack_cnt + 1;
        lat = 0;
        while (ack_cnt < target && lat < 3000) begin
            step();
            lat++;
        end
        if (ack_cnt < target) lat = -1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step();
        step();
        checks++;
        if ({bus.o_gen_rst_n, bus.o_err, bus.o_busy, bus.o_ack} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got rst_n/err/busy/ack=%b expected 0",
                     {bus.o_gen_rst_n, bus.o_err, bus.o_busy, bus.o_ack});
        end
        checks++;
        if ({bus.o_sel, bus.o_payload_length, bus.o_mode} !== '0) begin
            errors++;
            $display("FAIL reset_data: got sel=%0d len=%0d mode=%0d expected 0",
                     bus.o_sel, bus.o_payload_length, bus.o_mode);
        end
        checks++;
        if (bus.o_frame_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", bus.o_frame_cnt);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_single_frame();
        int n;
        int lat;
        bus.i_payload_length[0 +: 16] = 16'd46;
        bus.i_mode[0 +: 8] = 8'd0;
        exp_q.push_back('{0, 1'b0});
        bus.i_req = 4'b0001;
        wait_release(n);
        checks++;
        if (n >= 20) begin errors++; $display("FAIL single_release: got timeout expected release"); end
        checks++;
        if (bus.o_sel !== 2'd0 || bus.o_payload_length !== 16'd46 || bus.o_mode !== 8'd0 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got sel=%0d len=%0d mode=%0d busy=%b expected 0/46/0/1",
                     bus.o_sel, bus.o_payload_length, bus.o_mode, bus.o_busy);
        end
        wait_ack(lat);
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL single_latency: got %0d expected 12", lat); end
        checks++;
        if (bus.o_frame_cnt !== 32'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", bus.o_frame_cnt); end
        step();
        checks++;
        if (bus.o_gen_rst_n !== 1'b0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got rst_n=%b busy=%b expected 0/0", bus.o_gen_rst_n, bus.o_busy);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int lat;
        do_reset();
        bus.i_payload_length[2*16 +: 16] = 16'd60;
        bus.i_mode[2*8 +: 8] = 8'd0;
        exp_q.push_back('{0, 1'b0});
        exp_q.push_back('{2, 1'b0});
        bus.i_req = 4'b0101;
        wait_release(n);
        checks++;
        if (bus.o_sel !== 2'd0) begin errors++; $display("FAIL b2b_first_sel: got %0d expected 0", bus.o_sel); end
        wait_ack(lat);
        checks++;
        if (bus.o_sel !== 2'd2 || bus.o_gen_rst_n !== 1'b1 || bus.o_payload_length !== 16'd60) begin
            errors++;
            $display("FAIL b2b_switch: got sel=%0d rst_n=%b len=%0d expected 2/1/60",
                     bus.o_sel, bus.o_gen_rst_n, bus.o_payload_length);
        end
        wait_ack(lat);
        checks++;
        if (lat !== 13) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 13", lat); end
        checks++;
        if (bus.o_frame_cnt !== 32'd2) begin errors++; $display("FAIL b2b_cnt: got %0d expected 2", bus.o_frame_cnt); end
        step();
    endtask

    task automatic test_fairness();
        int n;
        int lat;
        int order[6];
        order = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int s = 0; s < N_REQ; s++) begin
            bus.i_payload_length[s*16 +: 16] = 16'd46;
            bus.i_mode[s*8 +: 8] = 8'd0;
        end
        for (int i = 0; i < 6; i++) exp_q.push_back('{order[i], 1'b0});
        hold_req = 1'b1;
        bus.i_req = 4'b1111;
        wait_release(n);
        for (int i = 0; i < 5; i++) begin
            wait_ack(lat);
            checks++;
            if (lat < 0 || int'(bus.o_sel) != order[i+1]) begin
                errors++;
                $display("FAIL fair_next_sel_%0d: got %0d expected %0d", i, bus.o_sel, order[i+1]);
            end
        end
        hold_req = 1'b0;
        bus.i_req = 4'b0010;
        wait_ack(lat);
        checks++;
        if (bus.o_frame_cnt !== 32'd6) begin errors++; $display("FAIL fair_cnt: got %0d expected 6", bus.o_frame_cnt); end
        step();
        checks++;
        if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL fair_idle: got busy=%b expected 0", bus.o_busy); end
    endtask

    task automatic test_watchdog();
        int n;
        int lat;
        do_reset();
        gen_en = 1'b0;
        exp_q.push_back('{0, 1'b1});
        bus.i_req = 4'b0001;
        wait_release(n);
        wait_ack(lat);
        checks++;
        if (lat !== TIMEOUT) begin errors++; $display("FAIL wd_latency: got %0d expected %0d", lat, TIMEOUT); end
        checks++;
        if (bus.o_err !== 1'b1 || bus.o_frame_cnt !== 32'd0) begin
            errors++;
            $display("FAIL wd_err_cnt: got err=%b cnt=%0d expected 1/0", bus.o_err, bus.o_frame_cnt);
        end
        step();
        checks++;
        if (bus.o_gen_rst_n !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_err !== 1'b0) begin
            errors++;
            $display("FAIL wd_idle: got rst_n=%b busy=%b err=%b expected 0/0/0", bus.o_gen_rst_n, bus.o_busy, bus.o_err);
        end
        gen_en = 1'b1;
    endtask

    task automatic test_odd_length();
        int n;
        int lat;
        bus.i_payload_length[0 +: 16] = 16'd40;
        bus.i_mode[0 +: 8] = NO_PADDING;
        exp_q.push_back('{0, 1'b0});
        bus.i_req = 4'b0001;
        wait_release(n);
        checks++;
        if (bus.o_payload_length !== 16'd40 || bus.o_mode !== 8'd2) begin
            errors++;
            $display("FAIL odd_grant: got len=%0d mode=%0d expected 40/2", bus.o_payload_length, bus.o_mode);
        end
        bus.i_payload_length[0 +: 16] = 16'd999;
        wait_ack(lat);
        checks++;
        if (lat !== 11) begin errors++; $display("FAIL odd_latency: got %0d expected 11", lat); end
        checks++;
        if (bus.o_frame_cnt !== 32'd1) begin errors++; $display("FAIL odd_cnt: got %0d expected 1", bus.o_frame_cnt); end
        step();
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int lat;
        bus.i_payload_length[0 +: 16] = 16'd46;
        bus.i_payload_length[16 +: 16] = 16'd46;
        bus.i_mode = '0;
        bus.i_req = 4'b0001;
        wait_release(n);
        for (int i = 0; i < 5; i++) step();
        bus.i_req = 4'b0011;
        i_rst = 1'b1;
        step();
        checks++;
        if ({bus.o_gen_rst_n, bus.o_err, bus.o_busy, bus.o_ack, bus.o_sel, bus.o_payload_length, bus.o_mode} !== '0
            || bus.o_frame_cnt !== 32'd0) begin
            errors++;
            $display("FAIL midrst_values: got rst_n=%b busy=%b ack=%b sel=%0d len=%0d cnt=%0d expected all 0",
                     bus.o_gen_rst_n, bus.o_busy, bus.o_ack, bus.o_sel, bus.o_payload_length, bus.o_frame_cnt);
        end
        bus.i_req = 4'b0010;
        i_rst = 1'b0;
        exp_q.push_back('{1, 1'b0});
        wait_release(n);
        checks++;
        if (bus.o_sel !== 2'd1) begin errors++; $display("FAIL midrst_regrant: got sel=%0d expected 1", bus.o_sel); end
        wait_ack(lat);
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL midrst_latency: got %0d expected 12", lat); end
    endtask

    initial begin
        i_rst = 1'b1;
        hold_req = 1'b0;
        gen_en = 1'b1;
        bus.i_req = '0;
        bus.i_payload_length = '0;
        bus.i_mode = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fairness();
        test_watchdog();
        test_odd_length();
        test_reset_mid_frame();
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
